// File: rtl/ad7606_emu_if.sv
// ad7606_emu_if: AD7606 parallel link between the FPGA-side controller (master) and the ADC emulator (slave).
interface ad7606_emu_if;
    logic        ad_reset;
    logic        ad_convstab;
    logic        ad_cs;
    logic        ad_rd;
    logic [2:0]  ad_os;
    logic [15:0] ad_data;
    logic        ad_busy;
    logic        first_data;
    logic        conv_err;
    modport master (
        output ad_reset, ad_convstab, ad_cs, ad_rd, ad_os,
        input  ad_data, ad_busy, first_data, conv_err
    );
    modport slave (
        input  ad_reset, ad_convstab, ad_cs, ad_rd, ad_os,
        output ad_data, ad_busy, first_data, conv_err
    );
endinterface

// File: rtl/ad7606_emu.sv
// ad7606_emu: cycle-based AD7606 parallel-interface responder returning a deterministic 8-channel frame.
// Define AD_EMU_OS_EN to scale the conversion length by the ad_os oversampling select.
module ad7606_emu #(
    parameter int CONV_CYCLES = 200,
    parameter int BUSY_DLY    = 2,
    parameter int CH_NUM      = 8
) (
    input logic         clk,
    input logic         rst_n,
    ad7606_emu_if.slave s
);
`ifdef AD_EMU_OS_EN
    localparam int CW = $clog2((CONV_CYCLES << 6) + BUSY_DLY + 1);
`else
    localparam int CW = $clog2(CONV_CYCLES + BUSY_DLY + 1);
`endif
    localparam int PW = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
    typedef enum logic [1:0] {IDLE, DELAY, CONV} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] conv_len;
    logic [PW-1:0] rd_ptr;
    logic [12:0]   frame_cnt;
    logic [15:0]   sample [CH_NUM];
    logic          conv_s, conv_p, rd_s, rd_p, cs_s;
    logic          conv_rise, rd_fall, rd_rise, conv_done;
`ifdef AD_EMU_OS_EN
    logic [2:0] os_q;
    assign conv_len = CW'(CONV_CYCLES) << os_q;
`else
    logic unused_os;
    assign unused_os = ^s.ad_os;
    assign conv_len  = CW'(CONV_CYCLES);
`endif
    assign conv_rise = conv_s & ~conv_p;
    assign rd_fall   = rd_p & ~rd_s & ~cs_s;
    assign rd_rise   = ~rd_p & rd_s & ~cs_s;
    assign conv_done = (state == CONV) && (cnt == conv_len - 1'b1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_ptr       <= '0;
            frame_cnt    <= '0;
            conv_s       <= 1'b0;
            conv_p       <= 1'b0;
            rd_s         <= 1'b1;
            rd_p         <= 1'b1;
            cs_s         <= 1'b1;
            s.ad_data    <= '0;
            s.ad_busy    <= 1'b0;
            s.first_data <= 1'b0;
            s.conv_err   <= 1'b0;
            for (int k = 0; k < CH_NUM; k++) sample[k] <= '0;
`ifdef AD_EMU_OS_EN
            os_q <= '0;
`endif
        end else begin
            conv_s <= s.ad_convstab;
            conv_p <= conv_s;
            rd_s   <= s.ad_rd;
            rd_p   <= rd_s;
            cs_s   <= s.ad_cs;
            if (s.ad_reset) begin
                state        <= IDLE;
                cnt          <= '0;
                rd_ptr       <= '0;
                frame_cnt    <= '0;
                s.ad_data    <= '0;
                s.ad_busy    <= 1'b0;
                s.first_data <= 1'b0;
                s.conv_err   <= 1'b0;
                for (int k = 0; k < CH_NUM; k++) sample[k] <= '0;
            end else begin
                if (conv_rise && state != IDLE) s.conv_err <= 1'b1;
                case (state)
                    IDLE: if (conv_rise) begin
                        state <= DELAY;
                        cnt   <= '0;
`ifdef AD_EMU_OS_EN
                        os_q  <= (s.ad_os == 3'b111) ? 3'b000 : s.ad_os;
`endif
                    end
                    DELAY: if (cnt == CW'(BUSY_DLY - 1)) begin
                        state     <= CONV;
                        cnt       <= '0;
                        s.ad_busy <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                    CONV: if (conv_done) begin
                        state     <= IDLE;
                        s.ad_busy <= 1'b0;
                        frame_cnt <= frame_cnt + 1'b1;
                        for (int k = 0; k < CH_NUM; k++) sample[k] <= {3'(k), frame_cnt};
                    end else cnt <= cnt + 1'b1;
                    default: state <= IDLE;
                endcase
                // a read launched on the conversion-end edge still returns the old frame
                if (rd_fall) begin
                    s.ad_data    <= sample[rd_ptr];
                    s.first_data <= (rd_ptr == '0);
                end
                if (conv_done) rd_ptr <= '0;
                else if (rd_rise) rd_ptr <= (rd_ptr == PW'(CH_NUM - 1)) ? '0 : rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ad7606_emu.sv
// tb_ad7606_emu: directed bench for ad7606_emu with a read scoreboard and a frame model.
// Build with AD_EMU_OS_EN defined to also exercise the oversampling lengths.
module tb_ad7606_emu;
    localparam int BUSY_DLY = 2;
    localparam int CONV_CYCLES = 200;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [15:0] m_lat [8];
    logic [12:0] m_frame = '0;
    int m_ptr = 0;
    logic [16:0] m_last = '0;
    logic [16:0] sb [$];
    ad7606_emu_if bus();
    ad7606_emu dut (.clk(clk), .rst_n(rst_n), .s(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) m_lat[k] = '0;
        m_frame = '0;
        m_ptr = 0;
        m_last = '0;
    endtask

    task automatic rd_one();
        logic [16:0] e;
        sb.push_back({m_ptr == 0, m_lat[m_ptr]});
        m_ptr = (m_ptr == 7) ? 0 : m_ptr + 1;
        bus.ad_rd = 1'b0;
        repeat (4) @(negedge clk);
        e = sb.pop_front();
        chk("rd_data", 32'(bus.ad_data), 32'(e[15:0]));
        chk("rd_first", 32'(bus.first_data), 32'(e[16]));
        m_last = e;
        bus.ad_rd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic read_win(input int n);
        @(negedge clk) bus.ad_cs = 1'b0;
        @(negedge clk);
        for (int i = 0; i < n; i++) rd_one();
        bus.ad_cs = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic start_conv();
        int n;
        n = 0;
        @(negedge clk) bus.ad_convstab = 1'b0;
        repeat (2) @(negedge clk);
        bus.ad_convstab = 1'b1;
        @(posedge clk);
        do begin @(posedge clk); #1; n++; end while (!bus.ad_busy && n < 20);
        chk("busy_dly", n, BUSY_DLY + 1);
        bus.ad_convstab = 1'b0;
    endtask

    task automatic finish_conv(input int len, input int glitch_at);
        int m;
        m = 0;
        do begin
            if (m == glitch_at) bus.ad_convstab = 1'b1;
            @(posedge clk); #1; m++;
        end while (bus.ad_busy && m < 20000);
        chk("busy_len", m, len);
        for (int k = 0; k < 8; k++) m_lat[k] = {3'(k), m_frame};
        m_frame++;
        m_ptr = 0;
    endtask

    initial begin
        bus.ad_reset = 1'b0;
        bus.ad_convstab = 1'b0;
        bus.ad_cs = 1'b1;
        bus.ad_rd = 1'b1;
        bus.ad_os = 3'b000;
        model_clear();
        #22;
        chk("rst_busy", 32'(bus.ad_busy), 0);
        chk("rst_data", 32'(bus.ad_data), 0);
        rst_n = 1'b1;
        @(negedge clk) bus.ad_reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("adrst_busy", 32'(bus.ad_busy), 0);
        chk("adrst_first", 32'(bus.first_data), 0);
        chk("adrst_err", 32'(bus.conv_err), 0);
        chk("adrst_data", 32'(bus.ad_data), 0);
        bus.ad_reset = 1'b0;
        // frame 0 then frame 1, eight reads each
        start_conv();
        finish_conv(CONV_CYCLES, -1);
        read_win(8);
        start_conv();
        finish_conv(CONV_CYCLES, -1);
        read_win(8);
        // RD pulse with CS high leaves the output untouched
        @(negedge clk) bus.ad_rd = 1'b0;
        repeat (4) @(negedge clk);
        bus.ad_rd = 1'b1;
        repeat (3) @(negedge clk);
        chk("cs_hold_data", 32'(bus.ad_data), 32'(m_last[15:0]));
        chk("cs_hold_first", 32'(bus.first_data), 32'(m_last[16]));
        // nine reads in one window wrap to channel 0
        start_conv();
        finish_conv(CONV_CYCLES, -1);
        read_win(9);
        // CONVST during busy is ignored but flagged
        chk("err_before", 32'(bus.conv_err), 0);
        start_conv();
        finish_conv(CONV_CYCLES, 50);
        chk("err_set", 32'(bus.conv_err), 1);
        @(negedge clk) bus.ad_reset = 1'b1;
        @(negedge clk) bus.ad_reset = 1'b0;
        model_clear();
        chk("err_clr", 32'(bus.conv_err), 0);
        chk("clr_data", 32'(bus.ad_data), 0);
        // ad_reset in the middle of a conversion
        start_conv();
        finish_conv(CONV_CYCLES, -1);
        start_conv();
        repeat (100) @(posedge clk);
        #1 bus.ad_reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 32'(bus.ad_busy), 0);
        repeat (2) @(posedge clk);
        #1 bus.ad_reset = 1'b0;
        model_clear();
        start_conv();
        finish_conv(CONV_CYCLES, -1);
        read_win(2);
`ifdef AD_EMU_OS_EN
        bus.ad_os = 3'b010;
        start_conv();
        finish_conv(CONV_CYCLES << 2, -1);
        bus.ad_os = 3'b111;
        start_conv();
        finish_conv(CONV_CYCLES, -1);
        read_win(1);
`endif
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
